// File: rtl/mcu_if_pkg.sv
// Shared definitions for the MCU command sequencer: command opcodes, nibble tag and FSM states.
package mcu_if_pkg;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_WR   = 3'b011;
  localparam logic [2:0] OP_DREP = 3'b100;
  localparam logic [2:0] OP_OUT  = 3'b101;

  typedef enum logic {
    TAG_CMD,
    TAG_DATA
  } tag_e;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_e;

endpackage

// File: rtl/nibble_fifo.sv
// Synchronous FIFO for tagged nibbles; a read and write in the same cycle while full both succeed.
module nibble_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_do_rd = i_rd & ~o_empty;
  // The read frees a slot in the same cycle, so a write into a full FIFO may proceed alongside it.
  assign w_do_wr = i_wr & (~o_full | w_do_rd);
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/mcu_cmd_sequencer.sv
// Synchronises MCU nibble strobes, tags/filters them, buffers them and replays them as clean en pulses.
module mcu_cmd_sequencer
  import mcu_if_pkg::*;
#(
  parameter int NIBBLE_W   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int EN_HIGH    = 2,
  parameter int EN_GAP     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mcu_strobe,
  input  logic [NIBBLE_W-1:0] mcu_nibble,
  input  logic                hold,
  output logic                en,
  output logic [NIBBLE_W-1:0] pc_out,
  output logic                expect_data,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                overflow,
  output logic [7:0]          drop_cnt
);

  localparam int MAX_CNT = (EN_HIGH > EN_GAP) ? EN_HIGH : EN_GAP;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT + 1) : 1;

  logic [2:0]          r_sync;
  logic                r_cap_data;
  logic                r_overflow;
  logic [7:0]          r_drop_cnt;
  logic                r_en;
  logic [NIBBLE_W-1:0] r_pc;
  logic                r_expect;
  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_rise;
  logic                w_is_inv;
  logic                w_cap_valid;
  logic                w_wr_ok;
  logic                w_pop;
  tag_e                w_tag;
  logic [NIBBLE_W:0]   w_wdata;
  logic [NIBBLE_W:0]   w_head;
  tag_e                w_head_tag;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  // Capture stage: two synchroniser flops plus one history flop for rising-edge detection
  assign w_rise      = r_sync[1] & ~r_sync[2];
  assign w_is_inv    = ~r_cap_data & (mcu_nibble[NIBBLE_W-1 -: 2] == 2'b11);
  assign w_cap_valid = w_rise & ~w_is_inv;
  assign w_wr_ok     = w_cap_valid & (~fifo_full | w_pop);
  assign w_tag       = r_cap_data ? TAG_DATA : TAG_CMD;
  assign w_wdata     = {logic'(w_tag), mcu_nibble};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync     <= '0;
      r_cap_data <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_sync <= {r_sync[1:0], mcu_strobe};
      // Only accepted writes advance the tagging state, so a lost command cannot shift later tags.
      if (w_wr_ok) r_cap_data <= r_cap_data ? 1'b0 : (mcu_nibble[NIBBLE_W-1 -: 3] == OP_WR);
      if (w_cap_valid & fifo_full & ~w_pop) r_overflow <= 1'b1;
      if (w_rise & w_is_inv & (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  nibble_fifo #(
    .WIDTH (NIBBLE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_wr_ok),
    .i_wdata (w_wdata),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign w_head_tag = tag_e'(w_head[NIBBLE_W]);

  // Issue stage: IDLE pops, PULSE holds for EN_HIGH, GAP for EN_GAP
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo_empty && !hold) begin
          w_pop       = 1'b1;
          w_state_nxt = PULSE;
          w_cnt_nxt   = '0;
        end
      end
      PULSE: begin
        if (r_cnt == CNT_W'(EN_HIGH - 1)) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == CNT_W'(EN_GAP - 1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // en trails the state by one edge so pc_out has settled a full cycle before en rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_en     <= 1'b0;
      r_pc     <= '0;
      r_expect <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= (r_state == PULSE);
      if (w_pop) begin
        r_pc     <= w_head[NIBBLE_W-1:0];
        r_expect <= (w_head_tag == TAG_CMD) && (w_head[NIBBLE_W-1 -: 3] == OP_WR);
      end
    end
  end

  assign en          = r_en;
  assign pc_out      = r_pc;
  assign expect_data = r_expect;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_mcu_cmd_sequencer.sv
// Directed-vector bench for mcu_cmd_sequencer: timing, tagging, drops, overflow, reset and full-FIFO pop.
module tb_mcu_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       mcu_strobe;
  logic [3:0] mcu_nibble;
  logic       hold;
  logic       en;
  logic [3:0] pc_out;
  logic       expect_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  mcu_cmd_sequencer #(
    .NIBBLE_W   (4),
    .FIFO_DEPTH (4),
    .EN_HIGH    (2),
    .EN_GAP     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mcu_strobe  (mcu_strobe),
    .mcu_nibble  (mcu_nibble),
    .hold        (hold),
    .en          (en),
    .pc_out      (pc_out),
    .expect_data (expect_data),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mcu_strobe = 1'b0;
    hold = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // One full strobe: high 4 cycles, low 4 cycles, nibble stable throughout.
  task automatic send(input logic [3:0] n);
    mcu_nibble = n;
    mcu_strobe = 1'b1;
    repeat (4) tick();
    mcu_strobe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", en); end
    checks++; if (pc_out !== 4'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    checks++; if (expect_data !== 1'b0) begin failures++; $display("FAIL reset_expect got=%b exp=0", expect_data); end
    checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", fifo_empty, fifo_full); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_ovf_drop got ovf=%b drop=%0d exp 0/0", overflow, drop_cnt); end
  endtask

  task automatic test_latency();
    mcu_nibble = 4'b0010;
    mcu_strobe = 1'b1;
    repeat (4) tick();
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL lat_en_early got=%b exp=0", en); end
    mcu_strobe = 1'b0;
    tick();
    checks++; if (en !== 1'b1) begin failures++; $display("FAIL lat_en_rise got=%b exp=1", en); end
    checks++; if (pc_out !== 4'b0010) begin failures++; $display("FAIL lat_pc got=%b exp=0010", pc_out); end
    checks++; if (expect_data !== 1'b0) begin failures++; $display("FAIL lat_expect got=%b exp=0", expect_data); end
    tick();
    checks++; if (en !== 1'b1) begin failures++; $display("FAIL lat_en_hold got=%b exp=1", en); end
    tick();
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL lat_en_fall got=%b exp=0", en); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL lat_drop got=%0d exp=0", drop_cnt); end
    tick();
  endtask

  // Issue one nibble and check the pulse, pc_out and expect_data it produces.
  task automatic issue_check(input logic [3:0] n, input logic exp_data, input string nm);
    mcu_nibble = n;
    mcu_strobe = 1'b1;
    repeat (4) tick();
    mcu_strobe = 1'b0;
    tick();
    checks++; if (en !== 1'b1 || pc_out !== n) begin failures++; $display("FAIL %s_issue got en=%b pc=%b exp en=1 pc=%b", nm, en, pc_out, n); end
    checks++; if (expect_data !== exp_data) begin failures++; $display("FAIL %s_expect got=%b exp=%b", nm, expect_data, exp_data); end
    repeat (3) tick();
  endtask

  task automatic test_data_tag();
    issue_check(4'b0110, 1'b1, "wr_cmd");
    issue_check(4'b1100, 1'b0, "wr_data");
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL data_not_dropped got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_drop();
    int pulses;
    pulses = 0;
    mcu_nibble = 4'b1110;
    mcu_strobe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) mcu_strobe = 1'b0;
      if (en === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL drop_no_pulse got=%0d exp=0", pulses); end
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_cnt1 got=%0d exp=1", drop_cnt); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL drop_empty got=%b exp=1", fifo_empty); end
    for (int i = 0; i < 254; i++) send(4'b1111);
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_cnt255 got=%0d exp=255", drop_cnt); end
    send(4'b1111);
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_saturate got=%0d exp=255", drop_cnt); end
  endtask

  task automatic test_overflow();
    int rises;
    logic prev;
    int rise_t [4];
    logic [3:0] rise_pc [4];
    do_reset();
    hold = 1'b1;
    for (int k = 0; k < 4; k++) send(4'(k));
    checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full4 got full=%b ovf=%b exp 1/0", fifo_full, overflow); end
    send(4'd4);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    send(4'd5);
    checks++; if (en !== 1'b0 || fifo_full !== 1'b1) begin failures++; $display("FAIL ovf_held got en=%b full=%b exp 0/1", en, fifo_full); end
    hold = 1'b0;
    rises = 0;
    prev = en;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (en === 1'b1 && prev === 1'b0) begin
        if (rises < 4) begin
          rise_t[rises] = t;
          rise_pc[rises] = pc_out;
        end
        rises++;
      end
      prev = en;
    end
    checks++; if (rises !== 4) begin failures++; $display("FAIL ovf_issue_count got=%0d exp=4", rises); end
    for (int k = 0; k < 4 && k < rises; k++) begin
      checks++; if (rise_pc[k] !== 4'(k) || rise_t[k] !== 2 + 5 * k) begin failures++; $display("FAIL ovf_issue%0d got pc=%b t=%0d exp pc=%b t=%0d", k, rise_pc[k], rise_t[k], 4'(k), 2 + 5 * k); end
    end
    checks++; if (fifo_empty !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got empty=%b ovf=%b exp 1/1", fifo_empty, overflow); end
  endtask

  task automatic test_reset_mid_pulse();
    int pulses;
    do_reset();
    hold = 1'b1;
    send(4'b0101);
    send(4'b0001);
    send(4'b0010);
    hold = 1'b0;
    repeat (2) tick();
    checks++; if (en !== 1'b1 || pc_out !== 4'b0101) begin failures++; $display("FAIL rstmid_pulse got en=%b pc=%b exp 1/0101", en, pc_out); end
    rst = 1'b1;
    tick();
    checks++; if (en !== 1'b0 || fifo_empty !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL rstmid_clear got en=%b empty=%b ovf=%b exp 0/1/0", en, fifo_empty, overflow); end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (en === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rstmid_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_full_pop_capture();
    int rises;
    logic prev;
    logic [3:0] exp_pc;
    do_reset();
    hold = 1'b1;
    for (int k = 0; k < 4; k++) send(4'(k));
    mcu_nibble = 4'b0100;
    mcu_strobe = 1'b1;
    repeat (2) tick();
    hold = 1'b0;
    tick();
    checks++; if (overflow !== 1'b0 || fifo_full !== 1'b1) begin failures++; $display("FAIL fullpop_accept got ovf=%b full=%b exp 0/1", overflow, fifo_full); end
    rises = 0;
    prev = en;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 2) mcu_strobe = 1'b0;
      if (en === 1'b1 && prev === 1'b0) begin
        exp_pc = 4'(rises);
        checks++; if (pc_out !== exp_pc) begin failures++; $display("FAIL fullpop_issue%0d got=%b exp=%b", rises, pc_out, exp_pc); end
        rises++;
      end
      prev = en;
    end
    checks++; if (rises !== 5) begin failures++; $display("FAIL fullpop_count got=%0d exp=5", rises); end
  endtask

  initial begin
    rst = 1'b1;
    mcu_strobe = 1'b0;
    mcu_nibble = 4'h0;
    hold = 1'b0;
    test_reset();
    test_latency();
    test_data_tag();
    test_drop();
    test_overflow();
    test_reset_mid_pulse();
    test_full_pop_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
